pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter NSTAGE, default 6, pipeline stage count; bit 0 = pc, ascending toward wb (0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb).
REQ-002 Parameter PC_W, default 32, width of the exception target address.
REQ-003 Parameter FLUSH_CYC, default 1, flush pulse length in cycles, legal range 1..15.
REQ-004 Parameter CNT_W, default 32, width of the stall performance counter.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 stallreq  in  NSTAGE  bit i = stage i requests a stall this cycle.
REQ-008 excp_req  in  1  exception/eret redirect request, sampled at clk rising edge.
REQ-009 excp_pc  in  PC_W  redirect target, sampled together with excp_req.
REQ-010 cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-011 stall  out  NSTAGE  bit i = 1 freezes stage i.
REQ-012 bubble  out  NSTAGE  bit i = 1 loads a NOP into stage i's input register.
REQ-013 flush  out  1  registered; clears all pipeline registers.
REQ-014 new_pc  out  PC_W  registered redirect address; valid while flush = 1.
REQ-015 busy  out  1  registered; 1 while the FSM is in FLUSH.
REQ-016 stall_cnt  out  CNT_W  count of cycles with stall[0] = 1.

Function
REQ-017 FSM states: RUN and FLUSH; 4-bit flush counter fcnt.
REQ-018 RUN stall/bubble decode, combinational: k = highest index with stallreq[k] = 1 (deepest stage wins).
REQ-019 RUN with a requester: stall[i] = 1 for i <= k, 0 above k.
REQ-020 RUN with a requester: bubble[k+1] = 1 when k+1 < NSTAGE; every other bubble bit = 0.
REQ-021 RUN with stallreq = 0: stall = 0, bubble = 0.
REQ-022 RUN with excp_req = 1 at an edge: next state FLUSH; flush = 1, busy = 1, new_pc = excp_pc and fcnt = FLUSH_CYC-1 from that edge.
REQ-023 Redirect latency: flush asserts exactly 1 cycle after the edge that sampled excp_req.
REQ-024 In the cycle excp_req is high in RUN, stall/bubble still follow the RUN decode.
REQ-025 FLUSH: stall = 0 and bubble = 0 regardless of stallreq; excp_req and excp_pc are ignored; new_pc holds.
REQ-026 FLUSH: fcnt decrements each edge; at the edge where fcnt = 0, return to RUN with flush = 0 and busy = 0.
REQ-027 flush stays high for exactly FLUSH_CYC consecutive cycles.
REQ-028 new_pc retains its last value after flush deasserts.
REQ-029 excp_req held high through FLUSH starts a new FLUSH only on the first edge after returning to RUN, so flush drops for at least 1 cycle between redirects.
REQ-030 stall_cnt increments by 1 on each edge where stall[0] = 1 (RUN only).
REQ-031 stall_cnt wraps from 2^CNT_W-1 to 0.
REQ-032 cnt_clr = 1 sets stall_cnt to 0 at the edge and wins over a simultaneous increment.

Reset
REQ-033 While resetn = 0, asynchronously: state = RUN, fcnt = 0, flush = 0, busy = 0, new_pc = 0, stall_cnt = 0.
REQ-034 While resetn = 0, stall and bubble are forced to 0 regardless of stallreq.
REQ-035 Reset asserted mid-FLUSH aborts the flush immediately; after release the block is in RUN with no pending redirect.

Verification
REQ-036 NSTAGE = 6, stallreq = 6'b000100 (id) -> stall = 6'b000111, bubble = 6'b001000, stall_cnt +1 per cycle.
REQ-037 stallreq = 6'b001100 (id+ex) -> stall = 6'b001111, bubble = 6'b010000 (ex wins).
REQ-038 FLUSH_CYC = 3, excp_req pulse with excp_pc = 32'hBFC00380 and stallreq = 6'b001000 held -> flush = 1 for 3 cycles starting 1 cycle later, new_pc = BFC00380, stall = 0 during flush, stall = 6'b001111 resumes after.
REQ-039 CNT_W = 4, stall[0] held 17 cycles -> stall_cnt 15 then 0 then 1; cnt_clr asserted on the same cycle as an increment -> 0.
REQ-040 resetn pulled low during the 2nd flush cycle -> flush, busy, new_pc and stall_cnt go to 0 at once; after release, no flush without a new excp_req.
REQ-041 excp_req held high for 6 cycles, FLUSH_CYC = 2 -> flush pattern 1,1,0,1,1 starting 1 cycle after the first sample.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: decodes per-stage stall requests into
// stall/bubble vectors and sequences exception/eret redirects as a
// fixed-length flush pulse. It also counts the cycles in which the pc stage was frozen.
module pipeline_ctrl #(
  parameter int NSTAGE    = 6,
  parameter int PC_W      = 32,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              excp_req,
  input  logic [PC_W-1:0]   excp_pc,
  input  logic              cnt_clr,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] bubble,
  output logic              flush,
  output logic [PC_W-1:0]   new_pc,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Counter load value: the flush spans FLUSH_CYC cycles, and the exit happens when fcnt reaches 0.
  localparam logic [3:0] FCNT_INIT = 4'(FLUSH_CYC - 1);

  state_t           state_reg, state_next;
  logic [3:0]       fcnt_reg, fcnt_next;
  logic             flush_reg, flush_next;
  logic             busy_reg, busy_next;
  logic [PC_W-1:0]  new_pc_reg, new_pc_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  // req_above[i]: some stage at i or deeper requests a stall, so stage i must
  // freeze. bubble_dec[i]: stage i-1 is the deepest requester, so stage i
  // gets a NOP while everything behind it holds.
  logic [NSTAGE-1:0] req_above;
  logic [NSTAGE-1:0] bubble_dec;
  logic              decode_en;

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_decode
      assign req_above[gi] = |stallreq[NSTAGE-1:gi];
      if (gi == 0) begin : g_b0
        assign bubble_dec[gi] = 1'b0;
      end else if (gi == NSTAGE - 1) begin : g_btop
        assign bubble_dec[gi] = stallreq[gi-1] & ~stallreq[gi];
      end else begin : g_bmid
        assign bubble_dec[gi] = stallreq[gi-1] & ~req_above[gi];
      end
    end
  endgenerate

  // Stall/bubble are only live in RUN and out of reset; the flush overrides them.
  always_comb begin
    stall     = '0;
    bubble    = '0;
    decode_en = resetn && (state_reg == RUN);
    if (decode_en) begin
      stall  = req_above;
      bubble = bubble_dec;
    end
  end

  // Next-state logic for the RUN/FLUSH sequencer and its registered outputs.
  always_comb begin
    state_next  = state_reg;
    fcnt_next   = fcnt_reg;
    flush_next  = flush_reg;
    busy_next   = busy_reg;
    new_pc_next = new_pc_reg;
    case (state_reg)
      RUN: begin
        if (excp_req) begin
          state_next  = FLUSH;
          fcnt_next   = FCNT_INIT;
          flush_next  = 1'b1;
          busy_next   = 1'b1;
          new_pc_next = excp_pc;
        end
      end
      FLUSH: begin
        // Redirect requests are ignored here, so back-to-back redirects
        // always see at least one RUN cycle with flush low.
        if (fcnt_reg == 4'd0) begin
          state_next = RUN;
          flush_next = 1'b0;
          busy_next  = 1'b0;
        end else begin
          fcnt_next = fcnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Stall-cycle counter: the clear wins over the increment, and the count wraps naturally.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (cnt_clr) begin
      stall_cnt_next = '0;
    end else if (stall[0]) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end
  end

  // State and output registers; reset aborts any flush in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= RUN;
      fcnt_reg      <= 4'd0;
      flush_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      new_pc_reg    <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      fcnt_reg      <= fcnt_next;
      flush_reg     <= flush_next;
      busy_reg      <= busy_next;
      new_pc_reg    <= new_pc_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign flush     = flush_reg;
  assign busy      = busy_reg;
  assign new_pc    = new_pc_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule
